// File: rtl/fir_decim.sv
// fir_decim: drops FIR warm-up samples, integrates-and-dumps DEC samples, then rounds/shifts/saturates
// each dump into a first-word-fall-through FIFO. Define FIR_DECIM_PEAK_EN to build the peak |result| tracker.
module fir_decim #(
   parameter int IWIDTH = 26,
   parameter int DEC    = 16,
   parameter int SHIFT  = 4,
   parameter int OWIDTH = 24,
   parameter int SKIP   = 10,
   parameter int FDEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          EN,
   input  logic signed [IWIDTH-1:0]      firsum,
   input  logic                          clr,
   output logic signed [OWIDTH-1:0]      dout,
   output logic                          dvalid,
   input  logic                          dready,
   output logic [$clog2(FDEPTH):0]       level,
   output logic                          ovf,
   output logic                          busy,
   output logic [OWIDTH-1:0]             peak
);

   localparam int AWIDTH = IWIDTH + $clog2(DEC);
   localparam int CW     = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int SKW    = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
   localparam int SKLAST = (SKIP > 1) ? SKIP - 1 : 0;
   localparam int PW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int LW     = $clog2(FDEPTH) + 1;
   localparam int RW     = (AWIDTH >= OWIDTH) ? AWIDTH + 1 : OWIDTH + 1;
   localparam int RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [RW-1:0] ONE   = 1;
   localparam logic signed [RW-1:0] RHALF = (SHIFT > 0) ? (ONE << RSH) : '0;
   localparam logic signed [RW-1:0] OMAX  = {{(RW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN  = {{(RW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACC} state_t;

   state_t                    state;
   logic [CW-1:0]             cnt;
   logic [SKW-1:0]            skcnt;
   logic signed [AWIDTH-1:0]  acc;
   logic signed [OWIDTH-1:0]  mem [FDEPTH];
   logic [PW-1:0]             wptr, rptr;

   logic                      accept, do_acc, last, push, pop, full, wr;
   logic signed [AWIDTH-1:0]  fs_ext;
   logic signed [RW-1:0]      acc_w, fs_w, sum_w, rnd, r;
   logic signed [OWIDTH-1:0]  rsat;

   // dout/dvalid is a valid/ready source: a word transfers on every edge where dvalid&dready;
   // dvalid never depends on dready, and dout stays stable while dvalid is high and unaccepted.
   assign dvalid = (level != '0);

   always_comb begin
      accept = EN && !clr;
      do_acc = accept && ((state == S_ACC) || ((state == S_IDLE) && (SKIP == 0)));
      last   = (cnt == CW'(DEC - 1));
      push   = do_acc && last;
      pop    = dvalid && dready;
      full   = (level == LW'(FDEPTH));
      wr     = push && (!full || pop);
      fs_ext = firsum;
      acc_w  = acc;
      fs_w   = firsum;
      sum_w  = acc_w + fs_w;
      rnd    = sum_w + RHALF;
      r      = rnd >>> SHIFT;
      if (r > OMAX)      rsat = OMAX[OWIDTH-1:0];
      else if (r < OMIN) rsat = OMIN[OWIDTH-1:0];
      else               rsat = r[OWIDTH-1:0];
   end

   always_ff @(posedge CLK) begin
      if (!RST || clr) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         skcnt <= '0;
         acc   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         dout  <= '0;
         ovf   <= 1'b0;
      end else begin
         if (accept) begin
            case (state)
               S_IDLE: begin
                  busy <= 1'b1;
                  if (SKIP > 1) begin
                     state <= S_SKIP;
                     skcnt <= SKW'(1);
                  end else begin
                     state <= S_ACC;
                  end
               end
               S_SKIP: begin
                  if (skcnt == SKW'(SKLAST)) begin
                     state <= S_ACC;
                     cnt   <= '0;
                  end else begin
                     skcnt <= skcnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
         // Dump clears acc/cnt in the same edge so the next sample starts a fresh frame.
         if (do_acc) begin
            if (last) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= acc + fs_ext;
               cnt <= cnt + 1'b1;
            end
         end
         if (wr) wptr <= wptr + 1'b1;
         if (push && full && !pop) ovf <= 1'b1;
         if (wr && !pop)      level <= level + 1'b1;
         else if (pop && !wr) level <= level - 1'b1;
         // dout is a registered copy of the head; it holds its last value once empty.
         if (pop) begin
            rptr <= rptr + 1'b1;
            if (level > LW'(1)) dout <= mem[rptr + 1'b1];
            else if (wr)        dout <= rsat;
         end else if (wr && (level == '0)) begin
            dout <= rsat;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST && !clr && wr) mem[wptr] <= rsat;
   end

`ifdef FIR_DECIM_PEAK_EN
   logic [OWIDTH-1:0] mag;

   always_comb begin
      if (!rsat[OWIDTH-1])                           mag = rsat;
      else if (rsat == {1'b1, {(OWIDTH-1){1'b0}}})   mag = {1'b0, {(OWIDTH-1){1'b1}}};
      else                                           mag = -rsat;
   end

   // Dropped results still count toward the peak.
   always_ff @(posedge CLK) begin
      if (!RST || clr)           peak <= '0;
      else if (push && mag > peak) peak <= mag;
   end
`else
   assign peak = '0;
`endif

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Downstream consumer of the polyphase FIR datapath's 26-bit firsum output.
- Discards the filter warm-up samples, then integrates-and-dumps DEC consecutive firsum values into one result.
- Each result is rounded, right-shifted and saturated to OWIDTH.
- Results are queued in a small first-word-fall-through FIFO, read out over a valid/ready handshake.

Parameters:
IWIDTH, 26, width of signed firsum input
DEC, 16, samples integrated per output word (>=1)
SHIFT, 4, arithmetic right shift applied to the dump sum (0 = none)
OWIDTH, 24, signed output word width
SKIP, 10, accepted samples discarded after leaving IDLE (FIR pipeline fill)
FDEPTH, 8, output FIFO depth (power of 2)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-low reset
EN  input  1  sample qualifier; same EN that drives the FIR datapath
firsum  input  IWIDTH  signed FIR sum, sampled when EN=1
clr  input  1  synchronous abort: drop partial frame, flush FIFO, clear ovf
dout  output  OWIDTH  signed head-of-FIFO result
dvalid  output  1  FIFO non-empty
dready  input  1  consumer accepts dout when dvalid&dready
level  output  clog2(FDEPTH)+1  FIFO occupancy
ovf  output  1  sticky: a result was dropped because FIFO was full
busy  output  1  state != IDLE
peak  output  OWIDTH  peak |result| (see Optional Feature)

Behaviour:
- Reset (RST=0 at CLK edge) values:
  - state=IDLE; accumulator and sample counter 0.
  - FIFO empty; level=0, dvalid=0, dout=0.
  - ovf=0, busy=0, peak=0.
- clr=1 has the same effect as reset, except RST has priority. Samples presented with clr=1 are ignored.
- Accepted sample: EN=1 at a rising edge. EN=0 freezes state, counter and accumulator (pause, not abort).
- State machine:
  - IDLE: on an accepted sample:
    - SKIP=0: the sample is accumulated as frame sample 1; go to ACC.
    - SKIP=1: the sample is discarded; go to ACC.
    - SKIP>1: the sample is discarded as skip #1; go to SKIP.
  - SKIP: discard accepted samples; after the SKIP-th discard go to ACC with counter=0.
  - ACC: acc += sign-extended firsum. On the DEC-th sample of a frame, dump and restart.
    - Dump: sum = acc + firsum; acc and counter are cleared in the same edge; no sample is lost between frames.
    - Remain in ACC until reset or clr.
- Arithmetic:
  - AWIDTH = IWIDTH + clog2(DEC).
  - If SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf); otherwise r = sum.
  - r is saturated to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
- Latency: the result is written into the FIFO at the edge accepting the DEC-th sample. dvalid rises in the next cycle if the FIFO was empty.
- FIFO rules:
  - Pop on dvalid&dready.
  - Push while full with no pop in the same edge: the word is dropped, ovf=1, level stays FDEPTH.
  - Push while full with a simultaneous pop: both happen, level unchanged, no ovf.
  - Push and pop when empty cannot coincide; the first word appears one cycle after the push.
- dout holds the head word until it is popped. When empty, dout holds its last value.
- ovf clears only on reset or clr.

Optional Feature:
- Macro FIR_DECIM_PEAK_EN.
- Defined: peak holds the max |r| over all results pushed since reset/clr. Dropped results also count. |-2^(OWIDTH-1)| saturates to 2^(OWIDTH-1)-1. peak updates at the push edge.
- Undefined: no peak logic is built; peak is tied to 0.

Test Plan:
1. DEC=4, SKIP=2, SHIFT=0; EN=1 with firsum=1,2,...,10 on consecutive cycles, dready=1 -> words 18 (3+4+5+6) then 34 (7..10); each dvalid is high 1 cycle after its 4th sample.
2. DEC=16, SKIP=0, SHIFT=0, OWIDTH=24; firsum=2^25-1 for 16 samples -> 8388607; then firsum=-2^25 for 16 samples -> -8388608.
3. DEC=4, SKIP=0, SHIFT=2; samples 1,1,1,1 -> 1; samples -3,0,0,0 -> -1; samples 2,0,0,0 -> 1.
4. FDEPTH=8, dready=0; produce 9 frames -> level=8, ovf=1, 9th word lost. Then set dready=1 -> frames 1..8 read in order, level back to 0, ovf remains 1.
5. EN toggled low for 5 cycles mid-frame -> output identical to the uninterrupted run. Assert clr (or RST=0) after 2 of 4 samples -> FIFO empty, busy=0, next frame is preceded by SKIP discards again. Full FIFO + push with simultaneous pop -> no ovf, level stays 8.
6. FIR_DECIM_PEAK_EN defined; results 5, -12, 7 -> peak 5, 12, 12. Macro undefined -> peak=0 throughout.
